dtw_accel_axil_regs: RTL and testbench

Parametrised AXI4-Lite register file for the DTW accelerator. It succeeds the fixed 8-register control/status slave and adds several capabilities: a configurable register count, per-register read-only/read-write selection, W1C interrupt status with enable and an `irq` output, independent AW/W acceptance, and SLVERR for unmapped addresses. It sits between the PS AXI interconnect and the DTW core, which consumes `cfg_out` and drives `ro_in` and `irq_event`.

---
 rtl/dtw_accel_axil_regs.sv | 188 ++++++++++++++++++
 tb/tb_dtw_accel_axil_regs.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_accel_axil_regs.sv
// AXI4-Lite register file for the DTW accelerator: control, status, W1C interrupt
// status/enable, reference length and a block of general RW/RO registers.
module dtw_accel_axil_regs #(
  parameter int                   C_S_AXI_DATA_WIDTH = 32,
  parameter int                   C_S_AXI_ADDR_WIDTH = 6,
  parameter int                   NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK            = 16'h0002,
  parameter int                   IRQ_W              = 8,
  parameter int unsigned          REF_LEN_DEFAULT    = 29898
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
  input  logic [IRQ_W-1:0]                       irq_event,
  output logic                                   irq
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = DW / 32 + 1;
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int RIDX_W   = $clog2(NUM_REGS);

  localparam int REG_CR       = 0;
  localparam int REG_SR       = 1;
  localparam int REG_IRQ_STAT = 2;
  localparam int REG_IRQ_EN   = 3;
  localparam int REG_REF_LEN  = 4;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] REF_DEF     = DW'(REF_LEN_DEFAULT);
  localparam logic [DW-1:0] IRQ_MASK    = DW'((65'd1 << IRQ_W) - 65'd1);

  // SR is always a mirror; bits 0,2,3,4 of RO_MASK cannot override fixed registers.
  function automatic logic is_ro(input int i);
    return (i == REG_SR) || ((i > REG_REF_LEN) && RO_MASK[i]);
  endfunction

  logic                aw_full;
  logic [IDX_W-1:0]    aw_idx;
  logic                w_full;
  logic [DW-1:0]       w_data;
  logic [SW-1:0]       w_strb;
  logic                wr_commit;
  logic                wr_ok;
  logic [DW-1:0]       wr_mask;
  logic [DW-1:0]       w1c;
  logic [NUM_REGS-1:0] wr_hit;
  logic                soft_rst_q;
  logic [DW-1:0]       regs [NUM_REGS];
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_ok;
  logic [DW-1:0]       rd_word;
  logic                unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, ro_in};

  assign S_AXI_AWREADY = !aw_full && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_full && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;

  assign wr_commit = aw_full && w_full;
  assign wr_ok     = 32'(aw_idx) < 32'(NUM_REGS);

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < SW; b++) begin
      wr_mask[b*8 +: 8] = {8{w_strb[b]}};
    end
  end

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = wr_commit && wr_ok && (32'(aw_idx) == 32'(i));
    end
  end

  assign w1c = wr_hit[REG_IRQ_STAT] ? (w_data & wr_mask) : '0;

  // Write address/data holding registers and write response.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full      <= 1'b0;
      aw_idx       <= '0;
      w_full       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Register storage; soft reset is applied one edge after the CR commit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      soft_rst_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == REG_REF_LEN) ? REF_DEF : '0;
      end
    end else begin
      soft_rst_q <= wr_hit[REG_CR] && wr_mask[0] && w_data[0];
      for (int i = 0; i < NUM_REGS; i++) begin
        if (is_ro(i)) begin
          regs[i] <= ro_in[i*DW +: DW];
        end else if (i == REG_IRQ_STAT) begin
          if (soft_rst_q) regs[i] <= '0;
          else            regs[i] <= ((regs[i] & ~w1c) | DW'(irq_event)) & IRQ_MASK;
        end else if (soft_rst_q) begin
          regs[i] <= (i == REG_REF_LEN) ? REF_DEF : '0;
        end else if (wr_hit[i]) begin
          regs[i] <= (regs[i] & ~wr_mask) | (w_data & wr_mask);
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) irq <= 1'b0;
    else                irq <= |(regs[REG_IRQ_STAT] & regs[REG_IRQ_EN]);
  end

  always_comb begin
    cfg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cfg_out[i*DW +: DW] = regs[i];
    end
  end

  assign rd_idx  = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
  assign rd_ok   = 32'(rd_idx) < 32'(NUM_REGS);
  assign rd_word = regs[rd_idx[RIDX_W-1:0]];

  // Read data is taken from the register array before any same-edge write lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_ok ? rd_word : '0;
      S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dtw_accel_axil_regs.sv
// Directed bench for dtw_accel_axil_regs: reset state, write/read channels,
// SLVERR, RO mirroring, W1C interrupts and soft reset.
module tb_dtw_accel_axil_regs;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int NR = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    awaddr, araddr;
  logic             awvalid, wvalid, bready, arvalid, rready;
  logic             awready, wready, bvalid, arready, rvalid;
  logic [DW-1:0]    wdata, rdata;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp;
  logic [NR*DW-1:0] cfg_out, ro_in;
  logic [7:0]       irq_event;
  logic             irq;
  logic [31:0]      d;
  logic [1:0]       r;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dtw_accel_axil_regs #(.C_S_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_out(cfg_out), .ro_in(ro_in), .irq_event(irq_event), .irq(irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return cfg_out[i*DW +: DW];
  endfunction

  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 20) begin tick(); n++; end
    check("aw_ready_wait", awready, 1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] dat, input logic [3:0] s);
    int n = 0;
    wdata = dat; wstrb = s; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 20) begin tick(); n++; end
    check("w_ready_wait", wready, 1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    check("b_valid_wait", bvalid, 1);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] dat,
                           input logic [3:0] s, output logic [1:0] resp);
    send_aw(a);
    send_w(dat, s);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (arready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    check("r_latency", rvalid, 1);
    dat = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; ro_in = '0; irq_event = '0;
    repeat (3) tick();
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_irq", irq, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ref_len", word(4), 32'd29898);
    rst_n = 1'b1;
    tick();
    check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);
    check("rel_arready", arready, 1);
    axi_read(7'd16, d, r);
    check("rd_ref_len", d, 32'h0000_74CA);
    check("rd_ref_len_resp", r, 2'b00);
    axi_read(7'd0, d, r);
    check("rd_cr", d, 0);

    // AW at edge 0, W at edge 3, response expected at edge 4
    awaddr = 7'd16; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("aw_hold_awready", awready, 0);
    check("aw_hold_wready", wready, 1);
    tick(); tick();
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("pre_commit_bvalid", bvalid, 0);
    tick();
    check("commit_bvalid", bvalid, 1);
    check("commit_bresp", bresp, 2'b00);
    check("commit_cfg4", word(4), 32'h1234);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done", bvalid, 0);
    axi_read(7'd16, d, r);
    check("rd_back_4", d, 32'h1234);

    axi_write(7'd20, 32'hAABBCCDD, 4'b0010, r);
    check("strb_bresp", r, 2'b00);
    axi_read(7'd20, d, r);
    check("strb_rd5", d, 32'h0000_CC00);

    axi_write(7'd80, 32'hFFFF_FFFF, 4'hF, r);
    check("oor_bresp", r, 2'b10);
    axi_read(7'd80, d, r);
    check("oor_rresp", r, 2'b10);
    check("oor_rdata", d, 0);
    check("oor_no_alias", word(4), 32'h1234);

    ro_in[1*DW +: DW] = 32'hDEAD_BEEF;
    tick();
    axi_read(7'd4, d, r);
    check("ro_sr_read", d, 32'hDEAD_BEEF);
    axi_write(7'd4, 32'h1111_1111, 4'hF, r);
    check("ro_wr_bresp", r, 2'b00);
    axi_read(7'd4, d, r);
    check("ro_wr_ignored", d, 32'hDEAD_BEEF);

    axi_write(7'd12, 32'h3, 4'hF, r);
    irq_event = 8'h02;
    tick();
    irq_event = 8'h00;
    check("irq_stat_set", word(2), 32'h2);
    check("irq_one_edge", irq, 0);
    tick();
    check("irq_two_edges", irq, 1);
    axi_read(7'd8, d, r);
    check("rd_irq_stat", d, 32'h2);

    // W1C colliding with a new event on the same bit
    send_aw(7'd8);
    send_w(32'h2, 4'hF);
    irq_event = 8'h02;
    tick();
    irq_event = 8'h00;
    check("w1c_coll_bvalid", bvalid, 1);
    check("w1c_coll_stat", word(2), 32'h2);
    bready = 1'b1; tick(); bready = 1'b0;
    check("w1c_coll_irq", irq, 1);

    send_aw(7'd8);
    send_w(32'h2, 4'hF);
    tick();
    check("w1c_stat_clear", word(2), 0);
    check("w1c_irq_lag", irq, 1);
    bready = 1'b1; tick(); bready = 1'b0;
    check("w1c_irq_fall", irq, 0);

    irq_event = 8'h20;
    tick();
    irq_event = 8'h00;
    tick(); tick();
    check("masked_irq", irq, 0);
    check("masked_stat", word(2), 32'h20);
    axi_write(7'd8, 32'hFFFF_FFFF, 4'hF, r);
    check("w1c_all", word(2), 0);

    // Soft reset with BREADY held low
    axi_write(7'd16, 32'd5, 4'hF, r);
    check("ref_len_5", word(4), 32'd5);
    send_aw(7'd0);
    send_w(32'h1, 4'hF);
    tick();
    check("srst_bvalid", bvalid, 1);
    check("srst_cr_bit", word(0), 32'h1);
    check("srst_ref_pre", word(4), 32'd5);
    tick();
    check("srst_cr_clear", word(0), 0);
    check("srst_ref_def", word(4), 32'd29898);
    check("srst_irq_en", word(3), 0);
    check("srst_gen5", word(5), 0);
    check("srst_sr_kept", word(1), 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      check("hold_bvalid", bvalid, 1);
      check("hold_awready", awready, 0);
      if (k < 3) tick();
    end
    bready = 1'b1; tick(); bready = 1'b0;
    check("srst_b_done", bvalid, 0);
    check("srst_awready", awready, 1);

    // Reset asserted with a read response pending
    araddr = 7'd16; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("pend_rvalid", rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_rdata", rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_arready", arready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
